// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light sequencer: state codes, lamp patterns and default phase lengths.
package traffic_pkg;

    localparam int unsigned CNT_W_DEF   = 6;
    localparam int unsigned T_MAJ_G_DEF = 30;
    localparam int unsigned T_MAJ_Y_DEF = 5;
    localparam int unsigned T_MIN_G_DEF = 20;
    localparam int unsigned T_MIN_Y_DEF = 5;

    typedef enum logic [2:0] {
        ST_MAJ_G   = 3'd0,
        ST_MAJ_Y   = 3'd1,
        ST_MIN_G   = 3'd2,
        ST_MIN_Y   = 3'd3,
        ST_EMG_MAJ = 3'd4,
        ST_EMG_MIN = 3'd5
    } state_e;

    typedef struct packed {
        logic maj_r;
        logic maj_y;
        logic maj_g;
        logic min_r;
        logic min_y;
        logic min_g;
    } lamps_t;

    localparam lamps_t LAMPS_MAJ_G = lamps_t'(6'b001_100);
    localparam lamps_t LAMPS_MAJ_Y = lamps_t'(6'b010_100);
    localparam lamps_t LAMPS_MIN_G = lamps_t'(6'b100_001);
    localparam lamps_t LAMPS_MIN_Y = lamps_t'(6'b100_010);

    // Emergency states show the same lamps as the green they hold.
    function automatic lamps_t lamps_for(input state_e st);
        lamps_t l;
        case (st)
            ST_MAJ_G, ST_EMG_MAJ: l = LAMPS_MAJ_G;
            ST_MAJ_Y:             l = LAMPS_MAJ_Y;
            ST_MIN_G, ST_EMG_MIN: l = LAMPS_MIN_G;
            ST_MIN_Y:             l = LAMPS_MIN_Y;
            default:              l = LAMPS_MAJ_G;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_timer.sv
// Loadable down-counter for phase timing; load wins over tick, and the count stops at 1.
module traffic_timer #(
    parameter int unsigned CNT_W = 6,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic [CNT_W-1:0] cnt,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (tick && (cnt_q > CNT_W'(1))) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign expire = tick && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/traffic_fsm.sv
// Traffic-light sequencer: major/minor ring on a 1 Hz tick with emergency holds and soft restart.
module traffic_fsm
    import traffic_pkg::*;
#(
    parameter int unsigned T_MAJ_G = T_MAJ_G_DEF,
    parameter int unsigned T_MAJ_Y = T_MAJ_Y_DEF,
    parameter int unsigned T_MIN_G = T_MIN_G_DEF,
    parameter int unsigned T_MIN_Y = T_MIN_Y_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             s0_lvl,
    input  logic             s1_lvl,
    input  logic             s4_pulse,
    output logic             maj_r,
    output logic             maj_y,
    output logic             maj_g,
    output logic             min_r,
    output logic             min_y,
    output logic             min_g,
    output logic [CNT_W-1:0] cnt,
    output logic [2:0]       state_o,
    output logic             emerg
);

    localparam int unsigned T_MAX = (2 ** CNT_W) - 1;

    if (T_MAJ_G < 1 || T_MAJ_G > T_MAX || T_MAJ_Y < 1 || T_MAJ_Y > T_MAX ||
        T_MIN_G < 1 || T_MIN_G > T_MAX || T_MIN_Y < 1 || T_MIN_Y > T_MAX) begin : g_bad_param
        $error("traffic_fsm: phase duration outside [1, 2^CNT_W-1]");
    end

    localparam logic [CNT_W-1:0] LD_MAJ_G = CNT_W'(T_MAJ_G);
    localparam logic [CNT_W-1:0] LD_MAJ_Y = CNT_W'(T_MAJ_Y);
    localparam logic [CNT_W-1:0] LD_MIN_G = CNT_W'(T_MIN_G);
    localparam logic [CNT_W-1:0] LD_MIN_Y = CNT_W'(T_MIN_Y);

    state_e           state_q, state_d;
    lamps_t           lamps_q, lamps_d;
    logic             emerg_q, emerg_d;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             expire;

    traffic_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (LD_MAJ_G)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .tick     (tick),
        .cnt      (cnt),
        .expire   (expire)
    );

    // State and registered outputs share one edge so lamps never lag the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_MAJ_G;
            lamps_q <= LAMPS_MAJ_G;
            emerg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lamps_q <= lamps_d;
            emerg_q <= emerg_d;
        end
    end

    // Next state; every phase entry reloads the timer, which also swallows a coincident tick.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_val = '0;
        if (s4_pulse) begin
            state_d  = ST_MAJ_G;
            load     = 1'b1;
            load_val = LD_MAJ_G;
        end else if (s1_lvl) begin
            if (state_q != ST_EMG_MAJ) begin
                state_d = ST_EMG_MAJ;
                load    = 1'b1;
            end
        end else if (s0_lvl) begin
            if (state_q != ST_EMG_MIN) begin
                state_d = ST_EMG_MIN;
                load    = 1'b1;
            end
        end else begin
            case (state_q)
                ST_MAJ_G: if (expire) begin
                    state_d  = ST_MAJ_Y;
                    load     = 1'b1;
                    load_val = LD_MAJ_Y;
                end
                ST_MAJ_Y: if (expire) begin
                    state_d  = ST_MIN_G;
                    load     = 1'b1;
                    load_val = LD_MIN_G;
                end
                ST_MIN_G: if (expire) begin
                    state_d  = ST_MIN_Y;
                    load     = 1'b1;
                    load_val = LD_MIN_Y;
                end
                ST_MIN_Y: if (expire) begin
                    state_d  = ST_MAJ_G;
                    load     = 1'b1;
                    load_val = LD_MAJ_G;
                end
                ST_EMG_MAJ: begin
                    state_d  = ST_MAJ_Y;
                    load     = 1'b1;
                    load_val = LD_MAJ_Y;
                end
                ST_EMG_MIN: begin
                    state_d  = ST_MIN_Y;
                    load     = 1'b1;
                    load_val = LD_MIN_Y;
                end
                default: begin
                    state_d  = ST_MAJ_G;
                    load     = 1'b1;
                    load_val = LD_MAJ_G;
                end
            endcase
        end
    end

    always_comb begin
        lamps_d = lamps_for(state_d);
        emerg_d = (state_d == ST_EMG_MAJ) || (state_d == ST_EMG_MIN);
    end

    assign maj_r   = lamps_q.maj_r;
    assign maj_y   = lamps_q.maj_y;
    assign maj_g   = lamps_q.maj_g;
    assign min_r   = lamps_q.min_r;
    assign min_y   = lamps_q.min_y;
    assign min_g   = lamps_q.min_g;
    assign state_o = 3'(state_q);
    assign emerg   = emerg_q;

endmodule

// File: tb/tb_traffic_fsm.sv
// Scoreboard bench for traffic_fsm: a behavioural model queues expected outputs per edge.
module tb_traffic_fsm;

    localparam int unsigned CNT_W = 6;

    logic clk = 1'b0;
    logic rst, tick, s0_lvl, s1_lvl, s4_pulse;
    logic maj_r, maj_y, maj_g, min_r, min_y, min_g, emerg;
    logic [CNT_W-1:0] cnt;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string tag;
        int    st;
        int    lamps;
        int    cnt;
        int    emerg;
    } exp_t;

    exp_t exp_q[$];

    int m_st;
    int m_cnt;

    traffic_fsm #(
        .T_MAJ_G (3),
        .T_MAJ_Y (2),
        .T_MIN_G (2),
        .T_MIN_Y (1),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .s0_lvl   (s0_lvl),
        .s1_lvl   (s1_lvl),
        .s4_pulse (s4_pulse),
        .maj_r    (maj_r),
        .maj_y    (maj_y),
        .maj_g    (maj_g),
        .min_r    (min_r),
        .min_y    (min_y),
        .min_g    (min_g),
        .cnt      (cnt),
        .state_o  (state_o),
        .emerg    (emerg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Lamp order {maj_r, maj_y, maj_g, min_r, min_y, min_g}
    function automatic int lamps_of(input int st);
        case (st)
            0, 4: return 6'b001100;
            1:    return 6'b010100;
            2, 5: return 6'b100001;
            3:    return 6'b100010;
            default: return 0;
        endcase
    endfunction

    function automatic int dur_of(input int st);
        case (st)
            0: return 3;
            1: return 2;
            2: return 2;
            3: return 1;
            default: return 0;
        endcase
    endfunction

    // Reference behaviour: apply one edge of inputs to the model.
    task automatic model_step(input bit r, input bit tk, input bit a0, input bit a1, input bit a4);
        if (r || a4) begin
            m_st = 0; m_cnt = 3;
        end else if (a1) begin
            if (m_st != 4) begin m_st = 4; m_cnt = 0; end
        end else if (a0) begin
            if (m_st != 5) begin m_st = 5; m_cnt = 0; end
        end else if (m_st == 4) begin
            m_st = 1; m_cnt = 2;
        end else if (m_st == 5) begin
            m_st = 3; m_cnt = 1;
        end else if (tk) begin
            if (m_cnt > 1) m_cnt = m_cnt - 1;
            else begin
                m_st  = (m_st + 1) % 4;
                m_cnt = dur_of(m_st);
            end
        end
    endtask

    task automatic cyc(input string tag, input bit r, input bit tk,
                       input bit a0, input bit a1, input bit a4);
        exp_t e;
        exp_t got;
        rst = r; tick = tk; s0_lvl = a0; s1_lvl = a1; s4_pulse = a4;
        model_step(r, tk, a0, a1, a4);
        e.tag = tag; e.st = m_st; e.lamps = lamps_of(m_st);
        e.cnt = m_cnt; e.emerg = (m_st >= 4) ? 1 : 0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check({got.tag, ".state"}, int'(state_o), got.st);
        check({got.tag, ".lamps"}, int'({maj_r, maj_y, maj_g, min_r, min_y, min_g}), got.lamps);
        check({got.tag, ".cnt"},   int'(cnt), got.cnt);
        check({got.tag, ".emerg"}, int'(emerg), got.emerg);
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; s0_lvl = 1'b0; s1_lvl = 1'b0; s4_pulse = 1'b0;
        m_st = 0; m_cnt = 3;
        @(negedge clk);

        cyc("reset", 1, 0, 0, 0, 0);
        check("reset_cnt_const", int'(cnt), 3);

        // Full ring, idle cycle between ticks to show hold
        for (int i = 0; i < 8; i++) begin
            cyc("ring_tick", 0, 1, 0, 0, 0);
            cyc("ring_idle", 0, 0, 0, 0, 0);
        end
        check("ring_wrap_state", int'(state_o), 0);

        // Reach MIN_G cnt=2, then major emergency
        for (int i = 0; i < 5; i++) cyc("to_min_g", 0, 1, 0, 0, 0);
        cyc("s1_enter", 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cyc("s1_hold_tick", 0, 1, 0, 1, 0);
        cyc("s1_release", 0, 0, 0, 0, 0);
        check("s1_release_cnt", int'(cnt), 2);

        // Both levels, then drop s1, then drop s0
        cyc("both_enter", 0, 0, 1, 1, 0);
        cyc("drop_s1", 0, 0, 1, 0, 0);
        cyc("drop_s0", 0, 0, 0, 0, 0);
        check("drop_s0_state", int'(state_o), 3);

        // Soft restart from MIN_Y, then restart with s0 held
        cyc("s4_restart", 0, 0, 0, 0, 1);
        cyc("s4_with_s0", 0, 1, 1, 0, 1);
        cyc("s0_reenter", 0, 0, 1, 0, 0);
        cyc("s0_release", 0, 1, 0, 0, 0);
        cyc("min_y_tick", 0, 1, 0, 0, 0);

        // Reset coincident with tick mid-MAJ_Y
        for (int i = 0; i < 4; i++) cyc("to_maj_y", 0, 1, 0, 0, 0);
        cyc("rst_tick", 1, 1, 0, 0, 0);
        check("rst_tick_cnt", int'(cnt), 3);

        // Tick on entry and on release are swallowed
        cyc("s1_tick_enter", 0, 1, 0, 1, 0);
        cyc("s1_tick_release", 0, 1, 0, 0, 0);
        check("release_tick_cnt", int'(cnt), 2);
        cyc("after_release", 0, 1, 0, 0, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
